apb_mac_ctrl: RTL and testbench

APB3 slave that fronts the Booth radix-4 multiply-accumulate datapath. It holds the operand registers and starts the MAC by raising `mac_en`. It waits for `mac_ready`, then captures the accumulated result and reports status back to the bus. It is the initiating side of the MAC's `en`/`ready` handshake and the responding side of the APB bus.

---
 rtl/apb_mac_ctrl_if.sv | 23 ++
 rtl/apb_mac_ctrl.sv | 152 +++++++++++++++
 tb/tb_apb_mac_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_mac_ctrl_if.sv
// APB3 bus bundle between a bus master and the apb_mac_ctrl register slave.
interface apb_mac_ctrl_if #(
   parameter int PDATA_WIDTH = 32
);
   logic                   psel;
   logic                   penable;
   logic                   pwrite;
   logic [4:0]             paddr;
   logic [PDATA_WIDTH-1:0] pwdata;
   logic [PDATA_WIDTH-1:0] prdata;
   logic                   pready;
   logic                   pslverr;

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_mac_ctrl.sv
// APB3 register slave that launches the Booth MAC over an en/ready handshake and collects its result.
// Define APB_MAC_CTRL_IRQ_EN to add the registered completion interrupt output irq.
module apb_mac_ctrl #(
   parameter int OPERAND_WIDTH = 8,
   parameter int PDATA_WIDTH   = 32,
   parameter int TIMEOUT       = 15
) (
   input  logic                       clk,
   input  logic                       rst,
   apb_mac_ctrl_if.slave              apb,
   output logic                       mac_en,
   output logic [OPERAND_WIDTH-1:0]   mac_a,
   output logic [OPERAND_WIDTH-1:0]   mac_b,
   input  logic [2*OPERAND_WIDTH-1:0] mac_result,
   input  logic                       mac_ready
`ifdef APB_MAC_CTRL_IRQ_EN
   ,
   output logic                       irq
`endif
);

   localparam int RES_W = 2 * OPERAND_WIDTH;
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   localparam logic [2:0] REG_OPA    = 3'd0;
   localparam logic [2:0] REG_OPB    = 3'd1;
   localparam logic [2:0] REG_CTRL   = 3'd2;
   localparam logic [2:0] REG_STATUS = 3'd3;
   localparam logic [2:0] REG_RESULT = 3'd4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [OPERAND_WIDTH-1:0] opa;
   logic [OPERAND_WIDTH-1:0] opb;
   logic               irq_en;
   logic               done;
   logic               err;
   logic [RES_W-1:0]   result;
   logic [CNT_W-1:0]   tcnt;

   logic               access;
   logic               wr_acc;
   logic               rd_acc;
   logic [2:0]         sel;
   logic               addr_ok;
   logic               busy;
   logic               start_req;
   logic               start;
   logic               busy_reject;
   logic               capture;
   logic               expire;
   logic               unused_bits;

   assign access      = apb.psel & apb.penable;
   assign wr_acc      = access & apb.pwrite;
   assign rd_acc      = access & ~apb.pwrite;
   assign sel         = apb.paddr[4:2];
   assign addr_ok     = (sel <= REG_RESULT);
   assign busy        = (state != IDLE);
   assign start_req   = wr_acc & (sel == REG_CTRL) & apb.pwdata[0];
   assign start       = start_req & ~busy;
   // Operands and the start bit are frozen while the MAC owns them.
   assign busy_reject = wr_acc & busy & ((sel == REG_OPA) | (sel == REG_OPB) | start_req);
   assign capture     = (state == RUN) & mac_ready;
   assign expire      = (state == RUN) & ~mac_ready & (tcnt == CNT_W'(TIMEOUT - 1));

   assign unused_bits = ^{apb.paddr[1:0], apb.pwdata[PDATA_WIDTH-1:OPERAND_WIDTH]};

   assign apb.pready  = 1'b1;
   assign apb.pslverr = access & (~addr_ok | busy_reject);

   assign mac_en = (state == RUN);
   assign mac_a  = opa;
   assign mac_b  = opb;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         // NOTE: non-blocking so every register in this edge sees pre-edge values.
         state <= state_next;
      end
   end

   always_comb begin
      // NOTE: default first, so no branch can leave state_next unassigned and infer a latch.
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (capture || expire) state_next = DRAIN;
         DRAIN:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opa    <= '0;
         opb    <= '0;
         irq_en <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
         result <= '0;
         tcnt   <= '0;
      end else begin
         if (wr_acc && !busy && sel == REG_OPA) opa <= apb.pwdata[OPERAND_WIDTH-1:0];
         if (wr_acc && !busy && sel == REG_OPB) opb <= apb.pwdata[OPERAND_WIDTH-1:0];
         if (wr_acc && sel == REG_CTRL)         irq_en <= apb.pwdata[1];

         if (start)              tcnt <= '0;
         else if (state == RUN)  tcnt <= tcnt + CNT_W'(1);

         // Capture outranks a same-edge RESULT read; the read only clears done in IDLE.
         if (start)                                                   done <= 1'b0;
         else if (capture)                                            done <= 1'b1;
         else if (rd_acc && sel == REG_RESULT && state == IDLE)       done <= 1'b0;

         if (start)       err <= 1'b0;
         else if (expire) err <= 1'b1;

         if (capture) result <= mac_result;
      end
   end

`ifdef APB_MAC_CTRL_IRQ_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) irq <= 1'b0;
      else     irq <= irq_en & (done | err);
   end
`endif

   always_comb begin
      apb.prdata = '0;
      if (rd_acc) begin
         case (sel)
            REG_OPA:    apb.prdata = PDATA_WIDTH'(opa);
            REG_OPB:    apb.prdata = PDATA_WIDTH'(opb);
            REG_CTRL:   apb.prdata = PDATA_WIDTH'({irq_en, 1'b0});
            REG_STATUS: apb.prdata = PDATA_WIDTH'({err, done, busy});
            REG_RESULT: apb.prdata = PDATA_WIDTH'(result);
            default:    apb.prdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_mac_ctrl.sv
// Self-checking bench for apb_mac_ctrl: register table, hand-written handshake corner cases,
// and randomized traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_apb_mac_ctrl;
   localparam int W  = 8;
   localparam int PW = 32;
   localparam int TO = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   apb_mac_ctrl_if #(.PDATA_WIDTH(PW)) apb ();

   logic          mac_en;
   logic [W-1:0]  mac_a;
   logic [W-1:0]  mac_b;
   logic [2*W-1:0] mac_result;
   logic          mac_ready;
   logic          model_ready = 1'b0;
   logic          stray_ready = 1'b0;
`ifdef APB_MAC_CTRL_IRQ_EN
   logic          irq;
`endif

   apb_mac_ctrl #(.OPERAND_WIDTH(W), .PDATA_WIDTH(PW), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .apb       (apb),
      .mac_en    (mac_en),
      .mac_a     (mac_a),
      .mac_b     (mac_b),
      .mac_result(mac_result),
      .mac_ready (mac_ready)
`ifdef APB_MAC_CTRL_IRQ_EN
      ,
      .irq       (irq)
`endif
   );

   // MAC stand-in: product of the presented operands, ready in the lat-th enabled cycle (0 = never).
   int lat = 0;
   int en_cnt = 0;
   int cur_len = 0;
   int last_len = 0;
   assign mac_result = 16'(mac_a) * 16'(mac_b);
   assign mac_ready  = model_ready | stray_ready;

   always @(negedge clk) begin
      if (mac_en) begin
         en_cnt  = en_cnt + 1;
         cur_len = cur_len + 1;
      end else begin
         en_cnt = 0;
         if (cur_len != 0) last_len = cur_len;
         cur_len = 0;
      end
      model_ready = (lat != 0) && mac_en && (en_cnt == lat);
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic apb_xfer(input bit wr, input logic [4:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err);
      @(negedge clk);
      apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = wr; apb.paddr = addr; apb.pwdata = wdata;
      @(negedge clk);
      apb.penable = 1'b1;
      #1;
      rdata = apb.prdata;
      err   = apb.pslverr;
      @(posedge clk);
      #1;
      apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
   endtask

   task automatic rd_chk(input string name, input logic [4:0] addr, input logic [31:0] exp);
      logic [31:0] d;
      logic e;
      apb_xfer(1'b0, addr, '0, d, e);
      check({name, "_data"}, d, exp);
      check({name, "_err"}, {31'd0, e}, 32'd0);
   endtask

   task automatic wr_chk(input string name, input logic [4:0] addr, input logic [31:0] data,
                         input bit exp_err);
      logic [31:0] d;
      logic e;
      apb_xfer(1'b1, addr, data, d, e);
      check({name, "_err"}, {31'd0, e}, {31'd0, exp_err});
   endtask

   // Returns the length of the enable pulse in progress, or -1 if none ends within the bound.
   task automatic wait_run_end(output int len);
      bit seen = 1'b0;
      len = -1;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (mac_en) seen = 1'b1;
         else if (seen) begin
            #1;
            len = last_len;
            return;
         end
      end
   endtask

   typedef struct {
      bit          wr;
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      bit          err;
      string       name;
   } vec_t;

   function automatic vec_t v(bit wr, logic [4:0] addr, logic [31:0] wdata, logic [31:0] rdata,
                              bit err, string name);
      vec_t r;
      r.wr = wr; r.addr = addr; r.wdata = wdata; r.rdata = rdata; r.err = err; r.name = name;
      return r;
   endfunction

   vec_t vecs[14];

   // Transaction-level model used by the random phase.
   logic [W-1:0]    m_opa, m_opb;
   logic            m_irqen, m_done, m_err;
   logic [2*W-1:0]  m_result;

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_opa = '0; m_opb = '0; m_irqen = 1'b0; m_done = 1'b0; m_err = 1'b0; m_result = '0;
   endtask

   initial begin
      logic [31:0] d;
      logic        e;
      int          len;

      apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = '0; apb.pwdata = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset state
      check("rst_mac_en", {31'd0, mac_en}, 32'd0);
      check("rst_mac_a", {24'd0, mac_a}, 32'd0);
      check("rst_mac_b", {24'd0, mac_b}, 32'd0);
      check("rst_pready", {31'd0, apb.pready}, 32'd1);
      check("rst_pslverr", {31'd0, apb.pslverr}, 32'd0);
      check("rst_prdata", apb.prdata, 32'd0);
`ifdef APB_MAC_CTRL_IRQ_EN
      check("rst_irq", {31'd0, irq}, 32'd0);
`endif

      // Register map table
      vecs[0]  = v(1'b1, 5'h00, 32'hFFFF_FFA3, 32'h0,  1'b0, "wr_opa");
      vecs[1]  = v(1'b0, 5'h00, 32'h0,         32'hA3, 1'b0, "rd_opa");
      vecs[2]  = v(1'b1, 5'h04, 32'h1234_5601, 32'h0,  1'b0, "wr_opb");
      vecs[3]  = v(1'b0, 5'h05, 32'h0,         32'h01, 1'b0, "rd_opb_lowbits");
      vecs[4]  = v(1'b1, 5'h08, 32'h2,         32'h0,  1'b0, "wr_ctrl_ie");
      vecs[5]  = v(1'b0, 5'h08, 32'h0,         32'h2,  1'b0, "rd_ctrl_ie");
      vecs[6]  = v(1'b0, 5'h0C, 32'h0,         32'h0,  1'b0, "rd_status");
      vecs[7]  = v(1'b0, 5'h10, 32'h0,         32'h0,  1'b0, "rd_result");
      vecs[8]  = v(1'b0, 5'h14, 32'h0,         32'h0,  1'b1, "rd_bad14");
      vecs[9]  = v(1'b0, 5'h18, 32'h0,         32'h0,  1'b1, "rd_bad18");
      vecs[10] = v(1'b1, 5'h1C, 32'hFFFF_FFFF, 32'h0,  1'b1, "wr_bad1c");
      vecs[11] = v(1'b1, 5'h08, 32'h0,         32'h0,  1'b0, "wr_ctrl_0");
      vecs[12] = v(1'b0, 5'h08, 32'h0,         32'h0,  1'b0, "rd_ctrl_0");
      vecs[13] = v(1'b0, 5'h03, 32'h0,         32'hA3, 1'b0, "rd_opa_lowbits");
      for (int i = 0; i < 14; i++) begin
         apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, d, e);
         check({vecs[i].name, "_data"}, d, vecs[i].rdata);
         check({vecs[i].name, "_err"}, {31'd0, e}, {31'd0, vecs[i].err});
      end
      check("tbl_mac_a", {24'd0, mac_a}, 32'hA3);
      check("tbl_mac_b", {24'd0, mac_b}, 32'h01);
      check("tbl_mac_en", {31'd0, mac_en}, 32'd0);

      // Basic multiply: 3 * 5 with ready after 8 enabled cycles
      wr_chk("b_opa", 5'h00, 32'd3, 1'b0);
      wr_chk("b_opb", 5'h04, 32'd5, 1'b0);
      lat = 8;
      wr_chk("b_start", 5'h08, 32'h1, 1'b0);
      check("b_en_rise", {31'd0, mac_en}, 32'd1);
      wait_run_end(len);
      check("b_en_len", len, 32'd8);
      check("b_en_low", {31'd0, mac_en}, 32'd0);
      rd_chk("b_status", 5'h0C, 32'h2);
      rd_chk("b_result", 5'h10, 32'd15);
      rd_chk("b_status_clr", 5'h0C, 32'h0);

      // Busy protection
      wr_chk("p_start", 5'h08, 32'h1, 1'b0);
      wr_chk("p_opa_busy", 5'h00, 32'h7F, 1'b1);
      check("p_mac_a_held", {24'd0, mac_a}, 32'd3);
      wr_chk("p_restart", 5'h08, 32'h1, 1'b1);
      rd_chk("p_status_busy", 5'h0C, 32'h1);
      wait_run_end(len);
      check("p_en_len", len, 32'd8);
      rd_chk("p_status", 5'h0C, 32'h2);
      rd_chk("p_opa", 5'h00, 32'd3);
      rd_chk("p_result", 5'h10, 32'd15);

      // Timeout: ready never arrives
      lat = 0;
      wr_chk("t_opa", 5'h00, 32'd9, 1'b0);
      wr_chk("t_start", 5'h08, 32'h1, 1'b0);
      wait_run_end(len);
      check("t_en_len", len, TO);
      rd_chk("t_status", 5'h0C, 32'h4);
      rd_chk("t_result", 5'h10, 32'd15);

      // Completion with interrupt enabled
      wr_chk("i_opa", 5'h00, 32'h12, 1'b0);
      wr_chk("i_opb", 5'h04, 32'h34, 1'b0);
      lat = 4;
      wr_chk("i_start", 5'h08, 32'h3, 1'b0);
      wait_run_end(len);
      check("i_en_len", len, 32'd4);
`ifdef APB_MAC_CTRL_IRQ_EN
      check("i_irq_capture_edge", {31'd0, irq}, 32'd0);
      @(negedge clk);
      #1;
      check("i_irq_rise", {31'd0, irq}, 32'd1);
`endif
      rd_chk("i_status", 5'h0C, 32'h2);
      rd_chk("i_result", 5'h10, 32'h3A8);
`ifdef APB_MAC_CTRL_IRQ_EN
      check("i_irq_after_read", {31'd0, irq}, 32'd1);
      @(posedge clk);
      #1;
      check("i_irq_fall", {31'd0, irq}, 32'd0);
`endif
      rd_chk("i_ctrl", 5'h08, 32'h2);
      wr_chk("i_ctrl_off", 5'h08, 32'h0, 1'b0);

      // Capture and RESULT read on the same edge
      wr_chk("c_opa", 5'h00, 32'h0F, 1'b0);
      wr_chk("c_opb", 5'h04, 32'h11, 1'b0);
      lat = 2;
      wr_chk("c_start", 5'h08, 32'h1, 1'b0);
      rd_chk("c_result_old", 5'h10, 32'h3A8);
      check("c_en_fell", {31'd0, mac_en}, 32'd0);
      rd_chk("c_status_done", 5'h0C, 32'h2);
      rd_chk("c_result_new", 5'h10, 32'hFF);
      rd_chk("c_status_clr", 5'h0C, 32'h0);

      // Stray ready outside RUN
      wr_chk("s_opa", 5'h00, 32'h22, 1'b0);
      @(negedge clk);
      stray_ready = 1'b1;
      repeat (2) @(negedge clk);
      stray_ready = 1'b0;
      check("s_mac_en", {31'd0, mac_en}, 32'd0);
      rd_chk("s_status", 5'h0C, 32'h0);
      rd_chk("s_result", 5'h10, 32'hFF);

      // Randomized traffic against the transaction model
      pulse_reset();
      for (int it = 0; it < 60; it++) begin
         int          op;
         logic [31:0] val;
         logic [2:0]  sel;
         op  = $urandom_range(0, 6);
         val = $urandom;
         case (op)
            0: begin
               wr_chk("r_wr_opa", 5'h00, val, 1'b0);
               m_opa = val[W-1:0];
               check("r_mac_a", {24'd0, mac_a}, {24'd0, m_opa});
            end
            1: begin
               wr_chk("r_wr_opb", 5'h04, val, 1'b0);
               m_opb = val[W-1:0];
               check("r_mac_b", {24'd0, mac_b}, {24'd0, m_opb});
            end
            2: begin
               logic [31:0] exp;
               sel = 3'($urandom_range(0, 4));
               case (sel)
                  3'd0:    exp = {24'd0, m_opa};
                  3'd1:    exp = {24'd0, m_opb};
                  3'd2:    exp = {30'd0, m_irqen, 1'b0};
                  3'd3:    exp = {29'd0, m_err, m_done, 1'b0};
                  default: exp = {16'd0, m_result};
               endcase
               rd_chk("r_rd", {sel, val[1:0]}, exp);
               if (sel == 3'd4) m_done = 1'b0;
            end
            3: begin
               sel = 3'($urandom_range(5, 7));
               apb_xfer(val[31], {sel, val[1:0]}, val, d, e);
               check("r_bad_data", d, 32'd0);
               check("r_bad_err", {31'd0, e}, 32'd1);
            end
            4: begin
               wr_chk("r_wr_ie", 5'h08, {30'd0, val[1], 1'b0}, 1'b0);
               m_irqen = val[1];
            end
            default: begin
               int  l;
               bit  idle;
               l    = $urandom_range(1, 20);
               lat  = l;
               idle = 1'b0;
               wr_chk("r_start", 5'h08, {30'd0, val[1], 1'b1}, 1'b0);
               m_irqen = val[1];
               for (int p = 0; p < 20 && !idle; p++) begin
                  apb_xfer(1'b0, 5'h0C, '0, d, e);
                  idle = !d[0];
               end
               check("r_idle_bound", {31'd0, idle}, 32'd1);
               if (l <= TO) begin
                  m_done   = 1'b1;
                  m_err    = 1'b0;
                  m_result = 16'(m_opa) * 16'(m_opb);
               end else begin
                  m_done = 1'b0;
                  m_err  = 1'b1;
               end
               rd_chk("r_status", 5'h0C, {29'd0, m_err, m_done, 1'b0});
`ifdef APB_MAC_CTRL_IRQ_EN
               check("r_irq", {31'd0, irq}, {31'd0, m_irqen & (m_done | m_err)});
`endif
            end
         endcase
      end
      rd_chk("r_final_result", 5'h10, {16'd0, m_result});

      // Reset in the middle of a computation
      wr_chk("x_opa", 5'h00, 32'h55, 1'b0);
      wr_chk("x_opb", 5'h04, 32'h66, 1'b0);
      lat = 0;
      wr_chk("x_start", 5'h08, 32'h3, 1'b0);
      repeat (3) @(negedge clk);
      check("x_en_before", {31'd0, mac_en}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("x_en_async", {31'd0, mac_en}, 32'd0);
      check("x_mac_a", {24'd0, mac_a}, 32'd0);
      check("x_mac_b", {24'd0, mac_b}, 32'd0);
      check("x_pready", {31'd0, apb.pready}, 32'd1);
      check("x_prdata", apb.prdata, 32'd0);
`ifdef APB_MAC_CTRL_IRQ_EN
      check("x_irq", {31'd0, irq}, 32'd0);
`endif
      @(negedge clk);
      rst = 1'b0;
      rd_chk("x_status", 5'h0C, 32'h0);
      rd_chk("x_ctrl", 5'h08, 32'h0);
      rd_chk("x_result", 5'h10, 32'h0);
      check("x_en_after", {31'd0, mac_en}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

endmodule
